// File: rtl/hilo_muldiv_ctrl.sv
// HI/LO unit for a 32-bit MIPS-style pipeline: single-cycle MUL, 32-step
// restoring divide, MTHI/MTLO writes, with stall/busy/done handshake to the pipe.
module hilo_muldiv_ctrl (
  input  logic        clk,
  input  logic        resetn,
  input  logic        op_valid,
  input  logic [2:0]  op,
  input  logic [31:0] a,
  input  logic [31:0] b,
  input  logic        flush,
  output logic        stall,
  output logic        busy,
  output logic        done,
  output logic [31:0] hi,
  output logic [31:0] lo
);

  typedef enum logic [1:0] {S_IDLE, S_MUL, S_DIV} state_e;

  state_e      state_q, state_d;
  logic [4:0]  cnt_q, cnt_d;
  logic [31:0] opa_q, opa_d;
  logic [31:0] opb_q, opb_d;
  logic [31:0] rem_q, rem_d;
  logic [31:0] hi_q, hi_d;
  logic [31:0] lo_q, lo_d;
  logic        sgn_q, sgn_d;
  logic        qneg_q, qneg_d;
  logic        rneg_q, rneg_d;

  function automatic logic [31:0] cond_neg(input logic [31:0] v, input logic neg);
    return neg ? (~v + 32'd1) : v;
  endfunction

  logic        is_idle, is_mul, is_div;
  logic        accept, mt_wr;
  logic signed [63:0] mul_a, mul_b, prod;
  logic [32:0] shifted;
  logic        ge;
  logic [31:0] sub, rem_nxt, quot_nxt;

  assign is_idle = (state_q == S_IDLE);
  assign is_mul  = (state_q == S_MUL);
  assign is_div  = (state_q == S_DIV);

  // DIV/DIVU by zero is never accepted, so it can neither stall nor touch HI/LO.
  assign accept = is_idle & op_valid & ~flush & ~op[2] & ~(op[1] & (b == 32'd0));
  assign mt_wr  = is_idle & op_valid & ~flush & (op[2:1] == 2'b10);

  // Extending to 64 bits makes the truncated product correct for both signednesses.
  assign mul_a = {{32{sgn_q & opa_q[31]}}, opa_q};
  assign mul_b = {{32{sgn_q & opb_q[31]}}, opb_q};
  assign prod  = mul_a * mul_b;

  // One restoring step: opa_q shifts dividend bits out and quotient bits in.
  assign shifted  = {rem_q, opa_q[31]};
  assign ge       = (shifted >= {1'b0, opb_q});
  assign sub      = shifted[31:0] - opb_q;
  assign rem_nxt  = ge ? sub : shifted[31:0];
  assign quot_nxt = {opa_q[30:0], ge};

  assign done  = ~flush & (is_mul | (is_div & (cnt_q == 5'd31)));
  assign stall = (is_idle & accept) | ((is_mul | is_div) & ~done & ~flush);
  assign busy  = ~is_idle;
  assign hi    = hi_q;
  assign lo    = lo_q;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    opa_d   = opa_q;
    opb_d   = opb_q;
    rem_d   = rem_q;
    hi_d    = hi_q;
    lo_d    = lo_q;
    sgn_d   = sgn_q;
    qneg_d  = qneg_q;
    rneg_d  = rneg_q;
    case (state_q)
      S_IDLE: begin
        if (accept && !op[1]) begin
          opa_d   = a;
          opb_d   = b;
          sgn_d   = ~op[0];
          state_d = S_MUL;
        end else if (accept) begin
          opa_d   = cond_neg(a, ~op[0] & a[31]);
          opb_d   = cond_neg(b, ~op[0] & b[31]);
          qneg_d  = ~op[0] & (a[31] ^ b[31]);
          rneg_d  = ~op[0] & a[31];
          rem_d   = 32'd0;
          cnt_d   = 5'd0;
          state_d = S_DIV;
        end
        if (mt_wr && op[0]) lo_d = a;
        if (mt_wr && !op[0]) hi_d = a;
      end
      S_MUL: begin
        state_d = S_IDLE;
        if (!flush) begin
          hi_d = prod[63:32];
          lo_d = prod[31:0];
        end
      end
      S_DIV: begin
        if (flush) begin
          state_d = S_IDLE;
        end else begin
          opa_d = quot_nxt;
          rem_d = rem_nxt;
          cnt_d = cnt_q + 5'd1;
          if (cnt_q == 5'd31) begin
            lo_d    = cond_neg(quot_nxt, qneg_q);
            hi_d    = cond_neg(rem_nxt, rneg_q);
            state_d = S_IDLE;
          end
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_q <= S_IDLE;
      cnt_q   <= 5'd0;
      opa_q   <= 32'd0;
      opb_q   <= 32'd0;
      rem_q   <= 32'd0;
      hi_q    <= 32'd0;
      lo_q    <= 32'd0;
      sgn_q   <= 1'b0;
      qneg_q  <= 1'b0;
      rneg_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      opa_q   <= opa_d;
      opb_q   <= opb_d;
      rem_q   <= rem_d;
      hi_q    <= hi_d;
      lo_q    <= lo_d;
      sgn_q   <= sgn_d;
      qneg_q  <= qneg_d;
      rneg_q  <= rneg_d;
    end
  end

endmodule

// File: tb/tb_hilo_muldiv_ctrl.sv
// Directed bench for hilo_muldiv_ctrl: table of complete operations plus
// hand-written flush, reset and back-to-back sequences.
module tb_hilo_muldiv_ctrl;

  logic        clk = 1'b0;
  logic        resetn;
  logic        op_valid;
  logic [2:0]  op;
  logic [31:0] a, b;
  logic        flush;
  logic        stall, busy, done;
  logic [31:0] hi, lo;

  int checks = 0;
  int errors = 0;

  hilo_muldiv_ctrl dut (
    .clk(clk), .resetn(resetn), .op_valid(op_valid), .op(op), .a(a), .b(b),
    .flush(flush), .stall(stall), .busy(busy), .done(done), .hi(hi), .lo(lo)
  );

  always #5 clk = ~clk;

  localparam logic [2:0] MULT = 3'b000, MULTU = 3'b001, DIV = 3'b010, DIVU = 3'b011;
  localparam logic [2:0] MTHI = 3'b100, MTLO = 3'b101, NOP = 3'b110;

  typedef struct packed {
    logic [2:0]  op;
    logic [31:0] a;
    logic [31:0] b;
    logic [5:0]  stalls;
    logic [5:0]  cyc;
    logic        done;
    logic [31:0] hi;
    logic [31:0] lo;
  } vec_t;

  vec_t tbl [15];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  // Starts just after a rising edge; presents one op, then follows it until idle.
  task automatic do_op(input string nm, input logic [2:0] o, input logic [31:0] av,
                       input logic [31:0] bv, input int exp_st, input int exp_cyc,
                       input int exp_dn, input logic [31:0] exp_hi, input logic [31:0] exp_lo);
    int st, dn, cyc;
    st = 0; dn = 0; cyc = 40;
    op_valid = 1'b1; op = o; a = av; b = bv;
    for (int c = 0; c < 40; c++) begin
      #1;
      if (stall) st++;
      if (done) dn++;
      @(posedge clk); #1;
      op_valid = 1'b0;
      if (!busy) begin
        cyc = c + 1;
        break;
      end
    end
    chk({nm, "_stall_cycles"}, st, exp_st);
    chk({nm, "_latency"}, cyc, exp_cyc);
    chk({nm, "_done_pulses"}, dn, exp_dn);
    chk({nm, "_hi"}, hi, exp_hi);
    chk({nm, "_lo"}, lo, exp_lo);
  endtask

  initial begin
    tbl[0]  = '{MTHI,  32'h11111111, 32'h0,        6'd0,  6'd1,  1'b0, 32'h11111111, 32'h00000000};
    tbl[1]  = '{MTLO,  32'h22222222, 32'h0,        6'd0,  6'd1,  1'b0, 32'h11111111, 32'h22222222};
    tbl[2]  = '{DIV,   32'h00000005, 32'h0,        6'd0,  6'd1,  1'b0, 32'h11111111, 32'h22222222};
    tbl[3]  = '{DIVU,  32'h00000005, 32'h0,        6'd0,  6'd1,  1'b0, 32'h11111111, 32'h22222222};
    tbl[4]  = '{MULT,  32'hFFFFFFFE, 32'h00000003, 6'd1,  6'd2,  1'b1, 32'hFFFFFFFF, 32'hFFFFFFFA};
    tbl[5]  = '{MULTU, 32'hFFFFFFFE, 32'h00000003, 6'd1,  6'd2,  1'b1, 32'h00000002, 32'hFFFFFFFA};
    tbl[6]  = '{DIV,   32'hFFFFFFF9, 32'h00000002, 6'd32, 6'd33, 1'b1, 32'hFFFFFFFF, 32'hFFFFFFFD};
    tbl[7]  = '{DIVU,  32'h00000007, 32'h00000002, 6'd32, 6'd33, 1'b1, 32'h00000001, 32'h00000003};
    tbl[8]  = '{DIV,   32'h80000000, 32'hFFFFFFFF, 6'd32, 6'd33, 1'b1, 32'h00000000, 32'h80000000};
    tbl[9]  = '{DIVU,  32'hFFFFFFFF, 32'h00000010, 6'd32, 6'd33, 1'b1, 32'h0000000F, 32'h0FFFFFFF};
    tbl[10] = '{DIV,   32'd100,      32'hFFFFFFF9, 6'd32, 6'd33, 1'b1, 32'h00000002, 32'hFFFFFFF2};
    tbl[11] = '{MULT,  32'h7FFFFFFF, 32'h80000000, 6'd1,  6'd2,  1'b1, 32'hC0000000, 32'h80000000};
    tbl[12] = '{NOP,   32'h12345678, 32'h9,        6'd0,  6'd1,  1'b0, 32'hC0000000, 32'h80000000};
    tbl[13] = '{MULTU, 32'h7FFFFFFF, 32'h80000000, 6'd1,  6'd2,  1'b1, 32'h3FFFFFFF, 32'h80000000};
    tbl[14] = '{DIV,   32'hFFFFFF9C, 32'hFFFFFFF9, 6'd32, 6'd33, 1'b1, 32'hFFFFFFFE, 32'h0000000E};

    resetn = 1'b0; op_valid = 1'b0; op = 3'b000; a = 32'd0; b = 32'd0; flush = 1'b0;
    #2;
    chk("rst_hi", hi, 32'h0);
    chk("rst_lo", lo, 32'h0);
    chk("rst_stall", {31'd0, stall}, 32'd0);
    chk("rst_busy", {31'd0, busy}, 32'd0);
    chk("rst_done", {31'd0, done}, 32'd0);
    @(posedge clk); #1;
    resetn = 1'b1;

    for (int i = 0; i < 15; i++)
      do_op($sformatf("vec%0d", i), tbl[i].op, tbl[i].a, tbl[i].b, int'(tbl[i].stalls),
            int'(tbl[i].cyc), int'(tbl[i].done), tbl[i].hi, tbl[i].lo);

    // flush in IDLE: MULT and MTLO both suppressed
    op_valid = 1'b1; op = MULT; a = 32'h5; b = 32'h5; flush = 1'b1; #1;
    chk("idle_flush_stall", {31'd0, stall}, 32'd0);
    @(posedge clk); #1;
    chk("idle_flush_busy", {31'd0, busy}, 32'd0);
    op = MTLO; a = 32'hDEADBEEF;
    @(posedge clk); #1;
    op_valid = 1'b0; flush = 1'b0;
    chk("idle_flush_mtlo", lo, 32'h0000000E);

    // flush during the MUL cycle
    op_valid = 1'b1; op = MULT; a = 32'h3; b = 32'h3;
    @(posedge clk); #1;
    op_valid = 1'b0; flush = 1'b1; #1;
    chk("mul_flush_done", {31'd0, done}, 32'd0);
    chk("mul_flush_stall", {31'd0, stall}, 32'd0);
    @(posedge clk); #1;
    flush = 1'b0;
    chk("mul_flush_busy", {31'd0, busy}, 32'd0);
    chk("mul_flush_hi", hi, 32'hFFFFFFFE);
    chk("mul_flush_lo", lo, 32'h0000000E);

    // DIV flushed at counter 10, then MTHI
    do_op("pre_hi", MTHI, 32'h11111111, 32'h0, 0, 1, 0, 32'h11111111, 32'h0000000E);
    do_op("pre_lo", MTLO, 32'h22222222, 32'h0, 0, 1, 0, 32'h11111111, 32'h22222222);
    op_valid = 1'b1; op = DIV; a = 32'hFFFFFFF9; b = 32'h2;
    @(posedge clk); #1;
    op_valid = 1'b0;
    repeat (10) @(posedge clk);
    #1;
    chk("div10_stall_pre", {31'd0, stall}, 32'd1);
    flush = 1'b1; #1;
    chk("div10_flush_stall", {31'd0, stall}, 32'd0);
    chk("div10_flush_done", {31'd0, done}, 32'd0);
    @(posedge clk); #1;
    flush = 1'b0; #1;
    chk("div10_busy", {31'd0, busy}, 32'd0);
    chk("div10_stall", {31'd0, stall}, 32'd0);
    chk("div10_hi", hi, 32'h11111111);
    chk("div10_lo", lo, 32'h22222222);
    do_op("mthi_after_flush", MTHI, 32'h12345678, 32'h0, 0, 1, 0, 32'h12345678, 32'h22222222);

    // reset at counter 20 of a DIV, then first edge after release accepts
    op_valid = 1'b1; op = DIV; a = 32'h00000064; b = 32'h7;
    @(posedge clk); #1;
    op_valid = 1'b0;
    repeat (20) @(posedge clk);
    #1;
    chk("div20_busy_pre", {31'd0, busy}, 32'd1);
    resetn = 1'b0; #1;
    chk("div20_rst_hi", hi, 32'h0);
    chk("div20_rst_lo", lo, 32'h0);
    chk("div20_rst_stall", {31'd0, stall}, 32'd0);
    chk("div20_rst_busy", {31'd0, busy}, 32'd0);
    @(posedge clk); #1;
    resetn = 1'b1;
    do_op("div_wrap", DIV, 32'h80000000, 32'hFFFFFFFF, 32, 33, 1, 32'h0, 32'h80000000);

    // MULT, MTHI ignored while busy, MTLO on the cycle after done
    op_valid = 1'b1; op = MULT; a = 32'h00010000; b = 32'h00030000;
    @(posedge clk); #1;
    op = MTHI; a = 32'h0000DEAD; #1;
    chk("b2b_done", {31'd0, done}, 32'd1);
    @(posedge clk); #1;
    chk("b2b_hi_prod", hi, 32'h00000003);
    chk("b2b_lo_prod", lo, 32'h00000000);
    op = MTLO; a = 32'hA5A5A5A5;
    @(posedge clk); #1;
    op_valid = 1'b0;
    chk("b2b_lo", lo, 32'hA5A5A5A5);
    chk("b2b_hi", hi, 32'h00000003);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/hilo_muldiv_ctrl.md
HILO_MULDIV_CTRL -- requirements
Module: hilo_muldiv_ctrl

Interface
REQ-001 The block SHALL have no parameters; the datapath is fixed at 32 bits and HI/LO at 32 bits each.
REQ-002 The block SHALL have one clock and an asynchronous, active-low reset, with the following ports:
  clk       in   1   single clock; all state on rising edge
  resetn    in   1   asynchronous active-low reset
  op_valid  in   1   EX-stage HI/LO operation present this cycle
  op        in   3   000 MULT, 001 MULTU, 010 DIV, 011 DIVU, 100 MTHI, 101 MTLO, others = no-op
  a         in  32   rs operand (dividend / multiplicand / move source)
  b         in  32   rt operand (divisor / multiplier)
  flush     in   1   exception/flush from pipeline control; cancels operation
  stall     out  1   combinational; holds the pipeline front end
  busy      out  1   registered; 1 while state != IDLE
  done      out  1   combinational; 1 in the final cycle of a MUL/DIV
  hi        out 32   architectural HI register
  lo        out 32   architectural LO register

Function
REQ-003 The state machine SHALL have three states: IDLE, MUL and DIV.
REQ-004 In IDLE, an accept SHALL occur when op_valid=1, op is in {000..011} and flush=0.
  - MULT/MULTU accept: latch a, b and the signed/unsigned flag; go to MUL.
  - DIV/DIVU accept with b!=0: latch |a| and |b| (for DIV) or a and b (for DIVU), plus the quotient sign (a[31]^b[31]) and remainder sign (a[31]); clear the 5-bit counter; go to DIV.
REQ-005 DIV/DIVU with b==0 SHALL NOT be accepted; the block SHALL stay in IDLE, leave HI/LO unchanged and keep stall=0.
REQ-006 MTHI/MTLO in IDLE with flush=0 SHALL write a into hi/lo, respectively, at the next edge; there SHALL be no stall and no state change.
REQ-007 stall SHALL equal (IDLE & accept) | ((MUL | DIV) & ~done & ~flush).
REQ-008 MUL SHALL last exactly one cycle, with done=1 in that cycle.
  - At its end edge, {hi,lo} SHALL be written with the 64-bit product (signed for MULT, unsigned for MULTU).
  - The state SHALL then return to IDLE.
REQ-009 DIV SHALL perform one restoring radix-2 step per cycle for 32 cycles (counter 0..31).
  - done=1 when counter==31.
  - At that edge, lo SHALL be written with the quotient and hi with the remainder, and the state SHALL return to IDLE.
REQ-010 Sign rules for DIV: the quotient SHALL be negated when the quotient sign is 1; the remainder SHALL be negated when the dividend sign is 1; the quotient truncates toward zero.
REQ-011 DIV of 0x80000000 by 0xFFFFFFFF SHALL yield lo=0x80000000 and hi=0x00000000 (wrap, no trap).
REQ-012 Latency, accept cycle to HI/LO valid:
  - MULT/MULTU: 2 cycles, with stall high for 1 cycle.
  - DIV/DIVU: 33 cycles, with stall high for 32 cycles.
REQ-013 flush=1 in MUL or DIV SHALL force done=0 and stall=0 that cycle; the next state SHALL be IDLE and HI/LO SHALL NOT be written.
REQ-014 flush=1 in IDLE SHALL suppress all accepts and MTHI/MTLO writes.
REQ-015 op_valid while busy=1 SHALL be ignored; no new operation is queued, and MTHI/MTLO SHALL NOT write.
REQ-016 done SHALL be 0 in IDLE, and busy SHALL be 0 in IDLE.

Reset
REQ-017 When resetn=0, the block SHALL immediately, independent of clk, set state=IDLE, counter=0, hi=0, lo=0 and all latched operands to 0; as a result stall=0, busy=0 and done=0.
REQ-018 Reset asserted mid-operation SHALL abandon the operation; no partial result SHALL reach hi/lo.
REQ-019 After resetn deasserts, the first rising edge SHALL be able to accept an operation.

Verification
REQ-020 MULT with a=0xFFFFFFFE, b=0x00000003 -> stall=1 for 1 cycle, done in the next cycle, then hi=0xFFFFFFFF and lo=0xFFFFFFFA. MULTU with the same operands -> hi=0x00000002, lo=0xFFFFFFFA.
REQ-021 DIV with a=0xFFFFFFF9, b=0x00000002 -> stall=1 for exactly 32 cycles, then lo=0xFFFFFFFD and hi=0xFFFFFFFF. DIVU with a=7, b=2 -> lo=3, hi=1.
REQ-022 DIV with b=0 and hi/lo preloaded to 0x11111111/0x22222222 -> stall never asserts and busy stays 0; hi/lo are unchanged.
REQ-023 Start DIV and assert flush at counter==10 -> next cycle busy=0, stall=0, hi/lo keep their prior values. A subsequent MTHI with a=0x12345678 -> hi=0x12345678 after one edge.
REQ-024 Pull resetn low at counter==20 of a DIV -> hi=lo=0 and stall=0 without a clock edge. After release, DIV 0x80000000 / 0xFFFFFFFF -> lo=0x80000000, hi=0.
REQ-025 Back-to-back MULT then MTLO (a=0xA5A5A5A5) presented on the cycle after done -> lo=0xA5A5A5A5, and hi keeps the product high word.
